// File: rtl/generador_clk.sv
// generador_clk: per-channel programmable clock dividers with a free-running
// pixel-rate divider. Every output comes straight from a register.
module generador_clk #(
    parameter  int NCH     = 2,
    parameter  int WIDTH   = 24,
    parameter  int DIV_RST = 12499999,
    parameter  int PIX_DIV = 2,
    localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             CLK_NX,
    input  logic             reset,
    input  logic [NCH-1:0]   en,
    input  logic             ld_we,
    input  logic [CH_W-1:0]  ld_ch,
    input  logic [WIDTH-1:0] ld_div,
    output logic             pixel_rate,
    output logic             pixel_tick,
    output logic [NCH-1:0]   clk_out,
    output logic [NCH-1:0]   tick
);

    localparam int PW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    logic [WIDTH-1:0] cnt_q [NCH];
    logic [WIDTH-1:0] cnt_d [NCH];
    logic [WIDTH-1:0] div_q [NCH];
    logic [WIDTH-1:0] div_d [NCH];
    logic [NCH-1:0]   clk_q, clk_d;
    logic [NCH-1:0]   tick_q, tick_d;
    logic [NCH-1:0]   ld_hit;

    logic [PW-1:0]    pix_cnt_q, pix_cnt_d;
    logic             pix_rate_q, pix_rate_d;
    logic             pix_tick_q, pix_tick_d;

    // Decode the write strobe; an out-of-range index matches no channel.
    always_comb begin
        ld_hit = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            ld_hit[i] = ld_we && (ld_ch == CH_W'(i));
        end
    end

    // Per-channel next state: a load beats the terminal count, disabled channels hold.
    always_comb begin
        clk_d  = clk_q;
        tick_d = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            cnt_d[i] = cnt_q[i];
            div_d[i] = div_q[i];
            if (ld_hit[i]) begin
                div_d[i] = ld_div;
                cnt_d[i] = '0;
            end else if (en[i]) begin
                if (cnt_q[i] == div_q[i]) begin
                    cnt_d[i]  = '0;
                    clk_d[i]  = ~clk_q[i];
                    tick_d[i] = ~clk_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + WIDTH'(1);
                end
            end
        end
    end

    // Free-running pixel divider next state.
    always_comb begin
        pix_cnt_d  = pix_cnt_q + PW'(1);
        pix_rate_d = pix_rate_q;
        pix_tick_d = 1'b0;
        if (pix_cnt_q == PW'(PIX_DIV - 1)) begin
            pix_cnt_d  = '0;
            pix_rate_d = ~pix_rate_q;
            pix_tick_d = ~pix_rate_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge CLK_NX) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
                div_q[i] <= WIDTH'(DIV_RST);
            end
            clk_q      <= '0;
            tick_q     <= '0;
            pix_cnt_q  <= '0;
            pix_rate_q <= 1'b0;
            pix_tick_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
                div_q[i] <= div_d[i];
            end
            clk_q      <= clk_d;
            tick_q     <= tick_d;
            pix_cnt_q  <= pix_cnt_d;
            pix_rate_q <= pix_rate_d;
            pix_tick_q <= pix_tick_d;
        end
    end

    assign clk_out    = clk_q;
    assign tick       = tick_q;
    assign pixel_rate = pix_rate_q;
    assign pixel_tick = pix_tick_q;

endmodule
